// File: rtl/sprite_move_ctl.sv
// Per-frame sprite position controller: samples buttons on the vblnk rising edge
// and updates xpos/ypos with saturating walk and a GROUND/RISE/FALL jump FSM.
module sprite_move_ctl #(
    parameter int unsigned X_INIT   = 100,
    parameter int unsigned Y_GROUND = 536,
    parameter int unsigned X_MAX    = 752,
    parameter int unsigned STEP_X   = 2,
    parameter int unsigned JUMP_V   = 12,
    parameter int unsigned V_MAX    = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        en,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        airborne,
    output logic        frame_tick
);

    typedef enum logic [1:0] {GROUND, RISE, FALL} vstate_e;

    localparam logic signed [12:0] STEP_S  = 13'(STEP_X);
    localparam logic signed [12:0] XMAX_S  = 13'(X_MAX);
    localparam logic signed [12:0] YG_S    = 13'(Y_GROUND);
    localparam logic        [11:0] XMAX_12 = 12'(X_MAX);
    localparam logic        [11:0] YG_12   = 12'(Y_GROUND);
    localparam logic        [11:0] XINIT_12 = 12'(X_INIT);
    localparam logic        [5:0]  JUMP_V6 = 6'(JUMP_V);
    localparam logic        [5:0]  VMAX_V6 = 6'(V_MAX);

    vstate_e            state_q;
    logic               vblnk_q;
    logic        [11:0] xpos_q;
    logic        [11:0] ypos_q;
    logic        [5:0]  vel_q;
    logic               airborne_q;
    logic               frame_tick_q;

    logic               tick;
    logic signed [12:0] x_ext;
    logic signed [12:0] x_sum;
    logic        [11:0] x_d;
    logic signed [12:0] y_ext;
    logic signed [12:0] v_ext;
    logic signed [12:0] y_up;
    logic signed [12:0] y_dn;
    logic        [11:0] rise_y_d;
    logic        [5:0]  vel_inc;

    assign tick = vblnk & ~vblnk_q & en;

    always_comb begin
        x_ext = signed'({1'b0, xpos_q});
        x_sum = x_ext;
        x_d   = xpos_q;
        if (btn_left && !btn_right) begin
            x_sum = x_ext - STEP_S;
            x_d   = x_sum[12] ? '0 : x_sum[11:0];
        end else if (btn_right && !btn_left) begin
            x_sum = x_ext + STEP_S;
            x_d   = (x_sum > XMAX_S) ? XMAX_12 : x_sum[11:0];
        end

        y_ext    = signed'({1'b0, ypos_q});
        v_ext    = signed'({7'b0, vel_q});
        y_up     = y_ext - v_ext;
        y_dn     = y_ext + v_ext;
        rise_y_d = y_up[12] ? '0 : y_up[11:0];
        vel_inc  = (vel_q >= VMAX_V6) ? VMAX_V6 : vel_q + 6'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_q      <= 1'b1;
            xpos_q       <= XINIT_12;
            ypos_q       <= YG_12;
            vel_q        <= '0;
            state_q      <= GROUND;
            airborne_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            vblnk_q      <= vblnk;
            frame_tick_q <= tick;
            if (tick) begin
                xpos_q <= x_d;
                unique case (state_q)
                    GROUND: begin
                        // Launch tick leaves ypos on the ground; motion starts next frame.
                        ypos_q <= YG_12;
                        vel_q  <= '0;
                        if (btn_jump) begin
                            state_q    <= RISE;
                            vel_q      <= JUMP_V6;
                            airborne_q <= 1'b1;
                        end
                    end
                    RISE: begin
                        ypos_q <= rise_y_d;
                        if (vel_q == 6'd1) begin
                            state_q <= FALL;
                            vel_q   <= 6'd1;
                        end else begin
                            vel_q <= vel_q - 6'd1;
                        end
                    end
                    FALL: begin
                        if (y_dn >= YG_S) begin
                            ypos_q     <= YG_12;
                            vel_q      <= '0;
                            state_q    <= GROUND;
                            airborne_q <= 1'b0;
                        end else begin
                            ypos_q <= y_dn[11:0];
                            vel_q  <= vel_inc;
                        end
                    end
                    default: state_q <= GROUND;
                endcase
            end
        end
    end

    assign xpos       = xpos_q;
    assign ypos       = ypos_q;
    assign airborne   = airborne_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sprite_move_ctl.sv
// Scoreboard bench for sprite_move_ctl: a frame-level model queues the expected
// position per tick, and a monitor checks ticks and hold-between-ticks behaviour.
module tb_sprite_move_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vblnk = 1'b1;
    logic        en = 1'b1;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_jump = 1'b0;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        airborne;
    logic        frame_tick;

    sprite_move_ctl #(
        .X_INIT(100), .Y_GROUND(536), .X_MAX(752),
        .STEP_X(2), .JUMP_V(4), .V_MAX(15)
    ) dut (
        .clk(clk), .rst(rst), .vblnk(vblnk), .en(en),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .xpos(xpos), .ypos(ypos), .airborne(airborne), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int air;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    // Per-tick ypos of a JUMP_V=4 jump, launch tick through landing tick.
    int traj [0:8] = '{536, 532, 529, 527, 526, 527, 529, 532, 536};
    int m_x = 100;
    int m_phase = -1;

    function automatic void chk(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endfunction

    function automatic void model_reset();
        m_x = 100;
        m_phase = -1;
        sb.delete();
    endfunction

    function automatic void model_tick(input bit l, input bit r, input bit j);
        exp_t e;
        if (l && !r) m_x = (m_x - 2 < 0) ? 0 : m_x - 2;
        else if (r && !l) m_x = (m_x + 2 > 752) ? 752 : m_x + 2;
        if (m_phase < 0) begin
            e.y = 536;
            e.air = j ? 1 : 0;
            if (j) m_phase = 0;
        end else begin
            m_phase++;
            e.y = traj[m_phase];
            e.air = 1;
            if (m_phase == 8) begin
                e.air = 0;
                m_phase = -1;
            end
        end
        e.x = m_x;
        sb.push_back(e);
    endfunction

    int h_x = 100, h_y = 536, h_air = 0;
    always @(negedge clk) begin
        if (rst) begin
            h_x = 100; h_y = 536; h_air = 0;
        end else if (frame_tick) begin
            if (sb.size() == 0) begin
                chk("spurious_tick", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("tick_xpos", int'(xpos), e.x);
                chk("tick_ypos", int'(ypos), e.y);
                chk("tick_airborne", int'(airborne), e.air);
                h_x = e.x; h_y = e.y; h_air = e.air;
            end
        end else begin
            chk("hold_xpos", int'(xpos), h_x);
            chk("hold_ypos", int'(ypos), h_y);
            chk("hold_airborne", int'(airborne), h_air);
        end
    end

    task automatic frame(input bit l, input bit r, input bit j, input bit e);
        @(posedge clk); #1;
        vblnk = 1'b0; btn_left = l; btn_right = r; btn_jump = j; en = e;
        repeat (3) @(posedge clk);
        #1;
        vblnk = 1'b1;
        if (e) model_tick(l, r, j);
        repeat (3) @(posedge clk);
    endtask

    // en returns mid-blank: the rising edge was seen while disabled, so no tick.
    task automatic frame_late_en();
        @(posedge clk); #1;
        vblnk = 1'b0; en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vblnk = 1'b1;
        @(posedge clk); #1;
        en = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic pulse_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        // Reset held with blanking high; release must not tick.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Walk right to 740, then saturate at 752.
        repeat (320) frame(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (30) frame(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (5) frame(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (400) frame(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) frame(1'b0, 1'b1, 1'b0, 1'b1);

        // Single-frame jump press, full trajectory.
        frame(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (9) frame(1'b0, 1'b0, 1'b0, 1'b1);

        // Pause after the 527 tick, then resume.
        frame(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) frame(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) frame(1'b1, 1'b0, 1'b1, 1'b0);
        frame_late_en();
        repeat (6) frame(1'b0, 1'b0, 1'b0, 1'b1);

        // Held jump relaunches the tick after landing.
        repeat (22) frame(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (10) frame(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset during RISE.
        frame(1'b1, 1'b0, 1'b1, 1'b1);
        repeat (2) frame(1'b1, 1'b0, 1'b0, 1'b1);
        pulse_reset(1);
        repeat (3) frame(1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized buttons and enable.
        for (int i = 0; i < 300; i++) begin
            frame(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 19) < 3), ($urandom_range(0, 19) != 0));
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sprite_move_ctl.md
# sprite_move_ctl

Per-frame position controller for the sprite rectangle drawer. Samples player buttons once per frame, at the rising edge of vertical blanking, and updates the `xpos`/`ypos` registers that drive the rectangle drawer. Handles horizontal walking and jumping with gravity through a three-state vertical FSM. Positions change only during blanking, so the drawn sprite never tears within a frame.

## Interface

**Parameters**
- `X_INIT`, 100: reset horizontal position (px).
- `Y_GROUND`, 536: ground row, top edge of the sprite (600 − 64).
- `X_MAX`, 752: maximum `xpos` (800 − 48).
- `STEP_X`, 2: horizontal step per frame (px).
- `JUMP_V`, 12: initial upward velocity (px/frame), range 1..V_MAX.
- `V_MAX`, 15: falling velocity cap (px/frame).

**Ports**
- `clk`, input, 1: pixel clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `vblnk`, input, 1: vertical blanking from the timing chain.
- `en`, input, 1: motion enable. 0 freezes all state (pause).
- `btn_left`, input, 1: walk left, level-sensitive.
- `btn_right`, input, 1: walk right, level-sensitive.
- `btn_jump`, input, 1: jump request, level-sensitive.
- `xpos`, output, 12: sprite left edge, registered.
- `ypos`, output, 12: sprite top edge, registered.
- `airborne`, output, 1: 1 when the FSM is in RISE or FALL, registered.
- `frame_tick`, output, 1: one-cycle pulse, registered copy of the internal tick.

## Operation

**Tick**
- `tick = vblnk & ~vblnk_d & en`, where `vblnk_d` is the registered `vblnk`.
- `vblnk_d` resets to 1. A `vblnk` that is high at reset release produces no tick.

**Horizontal update (on tick only)**
- Left only: `xpos <= max(0, xpos − STEP_X)`.
- Right only: `xpos <= min(X_MAX, xpos + STEP_X)`.
- Both or neither pressed: hold.
- Arithmetic is 13-bit signed. The result saturates and never wraps.

**Vertical FSM (`vel` is 6-bit unsigned; all transitions occur on tick only)**
- GROUND: `ypos = Y_GROUND`, `vel = 0`.
  - `btn_jump = 1` → RISE with `vel <= JUMP_V`. `ypos` is unchanged on this tick.
- RISE: `ypos <= max(0, ypos − vel)`.
  - If `vel == 1` → FALL with `vel <= 1`.
  - Otherwise `vel <= vel − 1`.
- FALL: if `ypos + vel >= Y_GROUND` → `ypos <= Y_GROUND`, `vel <= 0`, → GROUND.
  - Otherwise `ypos <= ypos + vel` and `vel <= min(vel + 1, V_MAX)`.
- `btn_jump` is ignored in RISE and FALL.
- Jump held through landing relaunches on the next tick after the landing tick, not on the landing tick itself.

**Horizontal and vertical** updates are independent and take effect on the same tick.

**Reset values**
- `xpos = X_INIT`, `ypos = Y_GROUND`.
- State GROUND, `vel = 0`.
- `airborne = 0`, `frame_tick = 0`, `vblnk_d = 1`.

**Reset mid-jump** returns to the reset values at the next edge. No partial motion remains.

## Timing

- Tick is combinational from `vblnk` and `vblnk_d`. It is asserted in the first cycle where `vblnk = 1` follows a cycle with `vblnk = 0`.
- `xpos`, `ypos`, `airborne` and `frame_tick` update at the clock edge ending the tick cycle. Latency is 1 cycle from the `vblnk` rising sample.
- `frame_tick` is high for exactly one cycle per frame while `en = 1`.
- Outputs are stable for the entire active video period, so the downstream rectangle drawer sees constant positions per frame.
- Buttons are sampled only in the tick cycle. Presses shorter than one frame that miss the tick cycle are lost, by design.
- When `en = 0`, no state or output changes and `frame_tick` stays 0. `vblnk_d` keeps tracking `vblnk`, so re-enabling mid-blank produces no tick until the next frame.

## Test plan

1. **Reset with blanking high.** Hold `rst` for 3 cycles with `vblnk = 1`, then release.
   - Outputs are `xpos = 100`, `ypos = 536`, `airborne = 0`.
   - No `frame_tick` until `vblnk` goes 0 then 1.
2. **Walk right and saturate.** Hold `btn_right` for 30 frames from `xpos = 740`.
   - Sequence is 742, 744, …, 752, then stays at 752.
   - Both buttons pressed: `xpos` holds.
   - Walk left from 1 with `STEP_X = 2`: `xpos` goes to 0.
3. **Jump trajectory.** Override `JUMP_V = 4`, press jump for one frame.
   - Per tick, `ypos` = 536 (launch), 532, 529, 527, 526, 527, 529, 532, 536.
   - `airborne` is 1 from the launch edge until the landing edge.
4. **Pause mid-jump.** Drop `en` after the 527 tick for 5 frames.
   - `ypos` stays at 527 and `frame_tick` stays 0.
   - After `en` returns to 1, the trajectory resumes at 526.
5. **Held jump and reset mid-air.**
   - Hold `btn_jump` continuously: after the landing tick (536), the next tick relaunches.
   - Assert `rst` during RISE: the next edge gives `ypos = 536` and `airborne = 0`.
